// File: rtl/alu_sin_receiver_pkg.sv
// alu_pkg: shared opcode, frame-type, error-index definitions and the CRC-4 helper.
package alu_pkg;

    typedef enum logic [2:0] {
        and_op = 3'b000,
        or_op  = 3'b001,
        add_op = 3'b100,
        sub_op = 3'b101
    } operation_t;

    localparam logic DATA = 1'b0;
    localparam logic CMD  = 1'b1;

    localparam int ERR_DATA = 2;
    localparam int ERR_CRC  = 1;
    localparam int ERR_OP   = 0;

    // CRC-4, x^4+x+1, init 0, message shifted in MSB first
    function automatic logic [3:0] crc4(input bit [67:0] msg);
        logic [3:0] c;
        c = '0;
        for (int i = 67; i >= 0; i--)
            c = {c[2:0], 1'b0} ^ ((msg[i] ^ c[3]) ? 4'b0011 : 4'b0000);
        return c;
    endfunction

endpackage

// File: rtl/alu_sin_receiver_if.sv
// alu_sin_receiver_if: serial input line and decoded-transaction outputs of the receiver.
interface alu_sin_receiver_if;
    logic        sin;
    logic        out_valid;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [2:0]  out_op;
    logic [2:0]  out_err;
    logic        busy;

    modport master (output sin, input out_valid, out_a, out_b, out_op, out_err, busy);
    modport slave  (input sin, output out_valid, out_a, out_b, out_op, out_err, busy);
endinterface

// File: rtl/alu_sin_receiver_framer.sv
// alu_sin_framer: bit-level start/type/payload/stop deserializer for 11-bit frames.
// word_valid_o/frame_err_o strobe while the stop bit is on the line so the word is consumed on the same edge.
module alu_sin_framer (
    input  logic       clk,
    input  logic       rst,
    input  logic       sin_i,
    output logic       word_valid_o,
    output logic       word_type_o,
    output logic [7:0] word_byte_o,
    output logic       frame_err_o,
    output logic       busy_o
);
    typedef enum logic [1:0] {IDLE, TYPE, PAYLOAD, STOP} state_t;

    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic       type_q;
    logic [7:0] byte_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            type_q    <= 1'b0;
            byte_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (!sin_i) state_q <= TYPE;
                TYPE: begin
                    type_q    <= sin_i;
                    bit_cnt_q <= '0;
                    state_q   <= PAYLOAD;
                end
                PAYLOAD: begin
                    byte_q    <= {byte_q[6:0], sin_i};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_q <= STOP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign word_valid_o = state_q == STOP && sin_i;
    assign frame_err_o  = state_q == STOP && !sin_i;
    assign word_type_o  = type_q;
    assign word_byte_o  = byte_q;
    assign busy_o       = state_q != IDLE;
endmodule

// File: rtl/alu_sin_receiver.sv
// alu_sin_receiver: word sequencing, operand assembly and CRC/opcode check of the ALU serial protocol.
// Optional ALU_SIN_RX_TIMEOUT_EN drops partial transactions after TIMEOUT_CYCLES idle cycles.
module alu_sin_receiver
    import alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32
) (
    input logic               clk,
    input logic               rst,
    alu_sin_receiver_if.slave bus
);
    logic        word_valid, word_type, frame_err, frm_busy;
    logic [7:0]  word_byte;
    logic [63:0] opnd_q;
    logic [3:0]  cnt_q;
    logic        ovf_q, out_valid_q;
    logic [31:0] out_a_q, out_b_q;
    logic [2:0]  out_op_q, out_err_q, err_d, op_d;
    logic        result_d, drop_d;

    alu_sin_framer u_framer (
        .clk          (clk),
        .rst          (rst),
        .sin_i        (bus.sin),
        .word_valid_o (word_valid),
        .word_type_o  (word_type),
        .word_byte_o  (word_byte),
        .frame_err_o  (frame_err),
        .busy_o       (frm_busy)
    );

    assign op_d     = word_byte[6:4];
    assign result_d = frame_err || (word_valid && word_type == CMD);

    // A framing error reports the same way as a bad word count
    always_comb begin
        err_d = '0;
        if (frame_err || cnt_q != 4'd8 || ovf_q) err_d[ERR_DATA] = 1'b1;
        else if (crc4({opnd_q, 1'b1, op_d}) != word_byte[3:0]) err_d[ERR_CRC] = 1'b1;
        else if (!(op_d inside {and_op, or_op, add_op, sub_op})) err_d[ERR_OP] = 1'b1;
    end

`ifdef ALU_SIN_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
    assign drop_d = !frm_busy && cnt_q != 4'd0 && tmo_q == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_q <= '0;
        else tmo_q <= (!frm_busy && cnt_q != 4'd0 && !drop_d) ? tmo_q + 1'b1 : '0;
    end
`else
    assign drop_d = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd_q      <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_op_q    <= '0;
            out_err_q   <= '0;
        end else begin
            out_valid_q <= result_d;
            if (result_d) begin
                out_err_q <= err_d;
                out_a_q   <= err_d == '0 ? opnd_q[31:0] : '0;
                out_b_q   <= err_d == '0 ? opnd_q[63:32] : '0;
                out_op_q  <= err_d == '0 ? op_d : '0;
                cnt_q     <= '0;
                ovf_q     <= 1'b0;
            end else if (word_valid) begin
                if (cnt_q == 4'd8) ovf_q <= 1'b1;
                else begin
                    opnd_q <= {opnd_q[55:0], word_byte};
                    cnt_q  <= cnt_q + 4'd1;
                end
            end else if (drop_d) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_op    = out_op_q;
    assign bus.out_err   = out_err_q;
    assign bus.busy      = frm_busy || cnt_q != 4'd0;
endmodule

// File: tb/tb_alu_sin_receiver.sv
// tb_alu_sin_receiver: randomized self-checking bench against a polynomial-division reference model.
module tb_alu_sin_receiver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_vec = 0, n_err = 0, pulses = 0, exp_pulses = 0;
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    logic [3:0]  rc;
    int          nd;

    alu_sin_receiver_if bus ();
    alu_sin_receiver dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(negedge clk) if (bus.out_valid) pulses++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // remainder of M(x)*x^4 divided by x^4+x+1
    function automatic logic [3:0] ref_crc(logic [31:0] b, logic [31:0] a, logic [2:0] op);
        logic [71:0] r;
        r = {b, a, 1'b1, op, 4'b0000};
        for (int i = 71; i >= 4; i--) if (r[i]) r[i-:5] = r[i-:5] ^ 5'b10011;
        return r[3:0];
    endfunction

    function automatic logic [2:0] model_err(logic [31:0] a, logic [31:0] b, logic [2:0] op,
                                             logic [3:0] crc, int ndata);
        if (ndata != 8) return 3'b100;
        if (crc != ref_crc(b, a, op)) return 3'b010;
        if (!(op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd5)) return 3'b001;
        return 3'b000;
    endfunction

    task automatic send_idle(int n);
        bus.sin = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(logic typ, logic [7:0] byt, logic stop);
        logic [10:0] f;
        f = {1'b0, typ, byt, stop};
        for (int i = 10; i >= 0; i--) begin
            bus.sin = f[i];
            @(posedge clk); #1;
        end
        bus.sin = 1'b1;
    endtask

    task automatic send_data(logic [63:0] ba, int n, int gmax);
        logic [7:0] byt;
        for (int i = 0; i < n; i++) begin
            byt = (i < 8) ? ba[63-8*i -: 8] : 8'($urandom);
            send_frame(1'b0, byt, 1'b1);
            send_idle($urandom_range(0, gmax));
        end
    endtask

    task automatic expect_result(string tag, logic [2:0] e, logic [31:0] a, logic [31:0] b, logic [2:0] op);
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_err"}, bus.out_err, e);
        chk({tag, "_a"}, bus.out_a, e == 3'b000 ? a : 32'd0);
        chk({tag, "_b"}, bus.out_b, e == 3'b000 ? b : 32'd0);
        chk({tag, "_op"}, bus.out_op, e == 3'b000 ? op : 3'd0);
        exp_pulses++;
        @(posedge clk); #1;
        chk({tag, "_width"}, bus.out_valid, 0);
        chk({tag, "_npulse"}, pulses, exp_pulses);
    endtask

    task automatic run_txn(string tag, logic [31:0] a, logic [31:0] b, logic [2:0] op,
                           logic [3:0] crc, int ndata, int gmax);
        send_data({b, a}, ndata, gmax);
        send_frame(1'b1, {1'b0, op, crc}, 1'b1);
        expect_result(tag, model_err(a, b, op, crc, ndata), a, b, op);
    endtask

    initial begin
        bus.sin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_a", bus.out_a, 0);
        chk("rst_b", bus.out_b, 0);
        chk("rst_op", bus.out_op, 0);
        chk("rst_err", bus.out_err, 0);
        chk("rst_busy", bus.busy, 0);
        send_idle(2);
        run_txn("zero", 32'd0, 32'd0, 3'b000, 4'b1011, 8, 0);
        run_txn("badcrc", 32'd0, 32'd0, 3'b000, 4'b1010, 8, 0);
        run_txn("badop", 32'hFFFF_FFFF, 32'h1234_5678, 3'b111,
                ref_crc(32'h1234_5678, 32'hFFFF_FFFF, 3'b111), 8, 1);
        run_txn("short", 32'hCAFE_0001, 32'h0BAD_F00D, 3'b100,
                ref_crc(32'h0BAD_F00D, 32'hCAFE_0001, 3'b100), 7, 0);
        run_txn("long", 32'hCAFE_0001, 32'h0BAD_F00D, 3'b100,
                ref_crc(32'h0BAD_F00D, 32'hCAFE_0001, 3'b100), 9, 0);
        send_data({$urandom, $urandom}, 4, 0);
        chk("ferr_busy", bus.busy, 1);
        send_frame(1'b0, 8'h3C, 1'b0);
        expect_result("ferr", 3'b100, 32'd0, 32'd0, 3'd0);
        ra = $urandom; rb = $urandom;
        run_txn("after_ferr", ra, rb, 3'b101, ref_crc(rb, ra, 3'b101), 8, 0);
        send_idle(5);
        chk("hold_a", bus.out_a, ra);
        chk("hold_b", bus.out_b, rb);
        for (int t = 0; t < 25; t++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = 3'($urandom);
            rc  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ref_crc(rb, ra, rop);
            nd  = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 7 : 9) : 8;
            run_txn($sformatf("rnd%0d", t), ra, rb, rop, rc, nd, 2);
        end
        ra = $urandom | 32'd1; rb = $urandom;
        run_txn("pre_rst", ra, rb, 3'b100, ref_crc(rb, ra, 3'b100), 8, 0);
        send_data({$urandom, $urandom}, 4, 0);
        bus.sin = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.sin = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_a", bus.out_a, 0);
        chk("midrst_b", bus.out_b, 0);
        chk("midrst_op", bus.out_op, 0);
        chk("midrst_err", bus.out_err, 0);
        chk("midrst_busy", bus.busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        send_idle(3);
        chk("midrst_npulse", pulses, exp_pulses);
        run_txn("post_rst", 32'd0, 32'd0, 3'b000, 4'b1011, 8, 0);
        send_data({$urandom, $urandom}, 3, 0);
        chk("partial_busy", bus.busy, 1);
`ifdef ALU_SIN_RX_TIMEOUT_EN
        send_idle(32);
        chk("tmo_busy", bus.busy, 0);
        chk("tmo_npulse", pulses, exp_pulses);
        run_txn("tmo_good", 32'd0, 32'd0, 3'b000, 4'b1011, 8, 0);
`else
        send_idle(40);
        chk("wait_busy", bus.busy, 1);
        send_frame(1'b1, 8'b0000_1011, 1'b1);
        expect_result("wait_cmd", model_err(32'd0, 32'd0, 3'b000, 4'b1011, 3), 32'd0, 32'd0, 3'd0);
`endif
        send_idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
